bcd_display_scanner: RTL and testbench

Multiplexed seven-segment scanner that reads the digits produced by the BCD counter chain and drives a common-anode NDIG-digit display. It captures a snapshot of the packed BCD digits, then time-multiplexes one digit at a time. Each digit is decoded to active-low segments, with optional leading-zero blanking and invalid-digit flagging. It sits between the counter stage and the board display pins.

---
 rtl/bcd_display_pkg.sv | 18 +
 rtl/seg7_decode.sv | 28 ++
 rtl/bcd_display_scanner.sv | 68 ++++++
 tb/tb_bcd_display_scanner.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: segment patterns and sizing helper shared by the display scanner
package bcd_display_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  function automatic int cnt_width(input int p);
    return p > 1 ? $clog2(p) : 1;
  endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: BCD digit to active-low gfedcba segments, dash for values above 9
// ports: digit in (DWL bits), seg out (7 bits, active low), invalid out (digit > 9)
module seg7_decode
  import bcd_display_pkg::*;
#(
  parameter int DWL = 4
) (
  input  logic [DWL-1:0] digit,
  output logic [6:0]     seg,
  output logic           invalid
);
  always_comb begin
    invalid = digit > DWL'(9);
    case (digit)
      DWL'(0): seg = SEG_0;
      DWL'(1): seg = SEG_1;
      DWL'(2): seg = SEG_2;
      DWL'(3): seg = SEG_3;
      DWL'(4): seg = SEG_4;
      DWL'(5): seg = SEG_5;
      DWL'(6): seg = SEG_6;
      DWL'(7): seg = SEG_7;
      DWL'(8): seg = SEG_8;
      DWL'(9): seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: multiplexed common-anode seven-segment scanner over a shadowed BCD snapshot
// ports: clk, clr_n (async active-low), enable, load, bcd_in/dp_in (snapshot source), blank_lz;
//        seg/dp/an (active low, registered), err (driven digit > 9)
module bcd_display_scanner
  import bcd_display_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int DWL = 4,
  parameter int PRESCALE = 100000
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                enable,
  input  logic                load,
  input  logic [NDIG*DWL-1:0] bcd_in,
  input  logic [NDIG-1:0]     dp_in,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [NDIG-1:0]     an,
  output logic                err
);
  localparam int CW = cnt_width(PRESCALE);
  localparam int IW = cnt_width(NDIG);
  logic [NDIG*DWL-1:0] shadow;
  logic [NDIG-1:0] shadow_dp;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [NDIG-1:0] zero_from;
  logic [DWL-1:0] digit;
  logic [6:0] dec_seg;
  logic tick, blank, invalid;
  // zero_from[i]: every shadow digit at position i and above is zero
  for (genvar g = 0; g < NDIG; g++) begin : g_lz
    assign zero_from[g] = (shadow >> (g * DWL)) == '0;
  end
  assign tick = enable && cnt == CW'(PRESCALE - 1);
  assign digit = shadow[idx*DWL +: DWL];
  assign blank = blank_lz && idx != '0 && zero_from[idx];
  seg7_decode #(.DWL(DWL)) u_dec (
    .digit(digit),
    .seg(dec_seg),
    .invalid(invalid)
  );
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      shadow <= '0;
      shadow_dp <= '0;
      cnt <= '0;
      idx <= '0;
      an <= '1;
      seg <= SEG_BLANK;
      dp <= 1'b1;
      err <= 1'b0;
    end else begin
      if (load) begin
        shadow <= bcd_in;
        shadow_dp <= dp_in;
      end
      if (enable) cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx == IW'(NDIG - 1) ? '0 : idx + 1'b1;
      an <= enable ? ~(NDIG'(1) << idx) : '1;
      seg <= enable && !blank ? dec_seg : SEG_BLANK;
      dp <= enable && !blank ? ~shadow_dp[idx] : 1'b1;
      err <= enable && !blank && invalid;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed stimulus checked every cycle against an arithmetic display model
module tb_bcd_display_scanner;
  localparam int NDIG = 4;
  localparam int DWL = 4;
  localparam int P = 4;
  localparam logic [6:0] TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  logic clk = 0, clr_n = 0, enable = 0, load = 0, blank_lz = 0;
  logic [15:0] bcd_in = '0;
  logic [3:0] dp_in = '0;
  logic [6:0] seg;
  logic dp, err;
  logic [3:0] an;
  int checks = 0, failures = 0;
  bit chk_on = 0;
  int n;
  logic [15:0] sh;
  logic [3:0] shdp, e_an, a_prev;
  logic [6:0] e_seg;
  logic e_dp, e_err;
  always #5 clk = ~clk;
  bcd_display_scanner #(.NDIG(NDIG), .DWL(DWL), .PRESCALE(P)) dut (
    .clk(clk), .clr_n(clr_n), .enable(enable), .load(load), .bcd_in(bcd_in),
    .dp_in(dp_in), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .err(err)
  );
  // n counts enabled edges since reset; the shown digit follows from it by division
  function automatic int idx_of(int k);
    return (k / P) % NDIG;
  endfunction
  function automatic logic [3:0] dig_of(logic [15:0] s, int i);
    return 4'((s >> (4 * i)) & 16'hF);
  endfunction
  function automatic bit blank_of(logic [15:0] s, int i, logic blz);
    return blz && i > 0 && (s >> (4 * i)) == 16'h0;
  endfunction
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      n <= 0;
      sh <= '0;
      shdp <= '0;
      e_an <= 4'hF;
      e_seg <= 7'h7F;
      e_dp <= 1'b1;
      e_err <= 1'b0;
    end else begin
      e_an <= enable ? ~(4'b1 << idx_of(n)) : 4'hF;
      e_seg <= !enable || blank_of(sh, idx_of(n), blank_lz) ? 7'h7F : TAB[dig_of(sh, idx_of(n))];
      e_dp <= !enable || blank_of(sh, idx_of(n), blank_lz) ? 1'b1 : ~shdp[idx_of(n)];
      e_err <= enable && dig_of(sh, idx_of(n)) > 4'd9;
      if (enable) n <= (n + 1) % (NDIG * P);
      if (load) begin
        sh <= bcd_in;
        shdp <= dp_in;
      end
    end
  end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_an", an, e_an);
      chk("model_seg", seg, e_seg);
      chk("model_dp", dp, e_dp);
      chk("model_err", err, e_err);
    end
  end
  task automatic wait_an(logic [3:0] a);
    int k = 0;
    while (an !== a && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("wait_an", an, a);
  endtask
  task automatic expect_slot(string nm, logic [3:0] a, logic [6:0] s, logic e, int len);
    int c = 0;
    wait_an(a);
    chk({nm, "_seg"}, seg, s);
    chk({nm, "_err"}, err, e);
    while (an === a && c < 20) begin
      c++;
      @(negedge clk);
    end
    chk({nm, "_len"}, c, len);
  endtask
  task automatic wait_n(int r);
    int k = 0;
    while (n % P != r && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      failures++;
      $display("FAIL wait_n timeout r=%0d", r);
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_an", an, 4'hF);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_err", err, 0);
    clr_n = 1;
    chk_on = 1;
    @(negedge clk);
    bcd_in = 16'h1234;
    load = 1;
    @(negedge clk);
    load = 0;
    enable = 1;
    expect_slot("run0", 4'hE, 7'h19, 0, 4);
    expect_slot("run1", 4'hD, 7'h30, 0, 4);
    expect_slot("run2", 4'hB, 7'h24, 0, 4);
    expect_slot("run3", 4'h7, 7'h79, 0, 4);
    bcd_in = 16'h0070;
    blank_lz = 1;
    load = 1;
    @(negedge clk);
    load = 0;
    expect_slot("bl1", 4'hD, 7'h78, 0, 4);
    expect_slot("bl2", 4'hB, 7'h7F, 0, 4);
    expect_slot("bl3", 4'h7, 7'h7F, 0, 4);
    expect_slot("bl0", 4'hE, 7'h40, 0, 4);
    bcd_in = 16'h0000;
    load = 1;
    @(negedge clk);
    load = 0;
    expect_slot("z2", 4'hB, 7'h7F, 0, 4);
    expect_slot("z3", 4'h7, 7'h7F, 0, 4);
    expect_slot("z0", 4'hE, 7'h40, 0, 4);
    expect_slot("z1", 4'hD, 7'h7F, 0, 4);
    bcd_in = 16'h00A5;
    load = 1;
    @(negedge clk);
    load = 0;
    expect_slot("inv3", 4'h7, 7'h7F, 0, 4);
    expect_slot("inv0", 4'hE, 7'h12, 0, 4);
    expect_slot("inv1", 4'hD, 7'h3F, 1, 4);
    expect_slot("inv2", 4'hB, 7'h7F, 0, 4);
    blank_lz = 0;
    while (n != 15) @(negedge clk);
    bcd_in = 16'h9876;
    dp_in = 4'b0101;
    load = 1;
    @(negedge clk);
    load = 0;
    @(negedge clk);
    chk("lt_an", an, 4'hE);
    chk("lt_seg", seg, 7'h02);
    chk("lt_dp", dp, 0);
    enable = 0;
    bcd_in = 16'h0002;
    dp_in = 4'b0000;
    load = 1;
    @(negedge clk);
    load = 0;
    chk("ld_dark_an", an, 4'hF);
    chk("ld_dark_seg", seg, 7'h7F);
    repeat (2) @(negedge clk);
    enable = 1;
    wait_n(2);
    a_prev = an;
    enable = 0;
    @(negedge clk);
    chk("frz_an", an, 4'hF);
    chk("frz_seg", seg, 7'h7F);
    chk("frz_err", err, 0);
    repeat (2) @(negedge clk);
    enable = 1;
    @(negedge clk);
    chk("res_a", an, a_prev);
    @(negedge clk);
    chk("res_b", an, a_prev);
    @(negedge clk);
    chk("res_next", an == a_prev, 0);
    wait_an(4'hB);
    #2 clr_n = 0;
    #1;
    chk("arst_an", an, 4'hF);
    chk("arst_seg", seg, 7'h7F);
    chk("arst_dp", dp, 1);
    chk("arst_err", err, 0);
    #1 clr_n = 1;
    @(negedge clk);
    expect_slot("ar0", 4'hE, 7'h40, 0, 4);
    expect_slot("ar1", 4'hD, 7'h40, 0, 4);
    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
